// File: rtl/uart_host_burst_if.sv
// Memory-bus side of the UART host bridge: shared address, a write channel and a
// read request/response channel, each with a valid/ready handshake.
interface uart_host_burst_if #(
    parameter int ADDR_BYTE = 2,
    parameter int DATA_BYTE = 2
) ();
    logic [8*ADDR_BYTE-1:0] address;
    logic                   wvalid;
    logic [8*DATA_BYTE-1:0] wdata;
    logic                   wready;
    logic                   rvalid;
    logic                   rready;
    logic                   rrvalid;
    logic [8*DATA_BYTE-1:0] rdata;

    modport master (
        output address, wvalid, wdata, rvalid,
        input  wready, rready, rrvalid, rdata
    );

    modport slave (
        input  address, wvalid, wdata, rvalid,
        output wready, rready, rrvalid, rdata
    );
endinterface

// File: rtl/uart_host_burst.sv
// Byte-stream host bridge: decodes UART command frames into single or burst bus
// reads/writes with address auto-increment, read timeout and a status byte per command.
module uart_host_burst #(
    parameter int ADDR_BYTE = 2,
    parameter int DATA_BYTE = 2,
    parameter int ADDR_INC  = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     rst_n_out,
    uart_host_burst_if.master        bus,
    output logic                     busy
);
    localparam int AW   = 8 * ADDR_BYTE;
    localparam int DW   = 8 * DATA_BYTE;
    localparam int MAXB = (ADDR_BYTE > DATA_BYTE) ? ADDR_BYTE : DATA_BYTE;
    localparam int BCW  = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTE - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0]  AINC      = AW'(ADDR_INC);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN     = 4'd1;
    localparam logic [3:0] S_ADDR    = 4'd2;
    localparam logic [3:0] S_DATA    = 4'd3;
    localparam logic [3:0] S_WR_BUS  = 4'd4;
    localparam logic [3:0] S_RD_REQ  = 4'd5;
    localparam logic [3:0] S_RD_WAIT = 4'd6;
    localparam logic [3:0] S_SEND    = 4'd7;
    localparam logic [3:0] S_STATUS  = 4'd8;

    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_BREAD  = 8'h03;
    localparam logic [7:0] CMD_BWRITE = 8'h04;
    localparam logic [7:0] CMD_RST_LO = 8'hFE;
    localparam logic [7:0] CMD_RST_HI = 8'hFF;
    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_ERR     = 8'hEE;

    logic [3:0]     state;
    logic [AW-1:0]  address;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rd_buf;
    logic           wvalid;
    logic           rvalid;
    logic [8:0]     words_left;
    logic [BCW-1:0] byte_cnt;
    logic [TW-1:0]  to_cnt;
    logic           is_write;
    logic           err;

    logic           overrun;
    logic           err_next;
    logic           last_word;
    logic [BCW+2:0] byte_ofs;
    logic [DW-1:0]  rd_shift;

    assign bus.address = address;
    assign bus.wvalid  = wvalid;
    assign bus.wdata   = wdata;
    assign bus.rvalid  = rvalid;
    assign busy        = (state != S_IDLE);

    // Bytes arriving while the bridge is busy on the bus or the transmitter are lost.
    assign overrun   = rx_valid && (state inside {S_WR_BUS, S_RD_REQ, S_RD_WAIT, S_SEND, S_STATUS});
    assign err_next  = err | overrun;
    assign last_word = (words_left == 9'd1);
    assign byte_ofs  = {byte_cnt, 3'b000};
    assign rd_shift  = rd_buf >> 8;

    // NOTE: every register here is updated with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            address    <= '0;
            wdata      <= '0;
            rd_buf     <= '0;
            wvalid     <= 1'b0;
            rvalid     <= 1'b0;
            words_left <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            is_write   <= 1'b0;
            err        <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            rst_n_out  <= 1'b0;
        end else begin
            if (overrun) err <= 1'b1;
            case (state)
                S_IDLE: if (rx_valid) begin
                    byte_cnt <= '0;
                    case (rx_data)
                        CMD_READ, CMD_WRITE: begin
                            words_left <= 9'd1;
                            is_write   <= (rx_data == CMD_WRITE);
                            state      <= S_ADDR;
                        end
                        CMD_BREAD, CMD_BWRITE: begin
                            is_write <= (rx_data == CMD_BWRITE);
                            state    <= S_LEN;
                        end
                        CMD_RST_LO: rst_n_out <= 1'b0;
                        CMD_RST_HI: rst_n_out <= 1'b1;
                        default: ;
                    endcase
                end
                S_LEN: if (rx_valid) begin
                    words_left <= {1'b0, rx_data} + 9'd1;
                    state      <= S_ADDR;
                end
                S_ADDR: if (rx_valid) begin
                    address[byte_ofs +: 8] <= rx_data;
                    if (byte_cnt == ADDR_LAST) begin
                        byte_cnt <= '0;
                        if (is_write) begin
                            state <= S_DATA;
                        end else begin
                            state  <= S_RD_REQ;
                            rvalid <= 1'b1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                end
                S_DATA: if (rx_valid) begin
                    wdata[byte_ofs +: 8] <= rx_data;
                    if (byte_cnt == DATA_LAST) begin
                        byte_cnt <= '0;
                        wvalid   <= 1'b1;
                        state    <= S_WR_BUS;
                    end else begin
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                end
                S_WR_BUS: if (wvalid && bus.wready) begin
                    wvalid     <= 1'b0;
                    address    <= address + AINC;
                    words_left <= words_left - 9'd1;
                    if (last_word) begin
                        state    <= S_STATUS;
                        tx_valid <= 1'b1;
                        tx_data  <= err_next ? ST_ERR : ST_OK;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_RD_REQ: if (rvalid && bus.rready) begin
                    rvalid <= 1'b0;
                    to_cnt <= '0;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (bus.rrvalid) begin
                        rd_buf   <= bus.rdata;
                        tx_data  <= bus.rdata[7:0];
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_SEND;
                    end else if (to_cnt == TO_LAST) begin
                        // No response: return a zero word and flag the command as failed.
                        rd_buf   <= '0;
                        tx_data  <= '0;
                        tx_valid <= 1'b1;
                        err      <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_SEND;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_SEND: if (tx_ready) begin
                    if (byte_cnt == DATA_LAST) begin
                        byte_cnt   <= '0;
                        address    <= address + AINC;
                        words_left <= words_left - 9'd1;
                        if (last_word) begin
                            state   <= S_STATUS;
                            tx_data <= err_next ? ST_ERR : ST_OK;
                        end else begin
                            state    <= S_RD_REQ;
                            rvalid   <= 1'b1;
                            tx_valid <= 1'b0;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BCW'(1);
                        rd_buf   <= rd_shift;
                        tx_data  <= rd_shift[7:0];
                    end
                end
                S_STATUS: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    err      <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_host_burst.sv
// Scoreboard bench for uart_host_burst: directed command frames push expected bus
// transactions and tx bytes; a negedge monitor pops and compares them as they appear.
module tb_uart_host_burst;
    localparam int AB = 2;
    localparam int DB = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       rst_n_out;
    logic       busy;

    uart_host_burst_if #(.ADDR_BYTE(AB), .DATA_BYTE(DB)) bus ();

    uart_host_burst #(
        .ADDR_BYTE(AB), .DATA_BYTE(DB), .ADDR_INC(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rst_n_out(rst_n_out),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  frame[$];

    int         tx_mode = 0;
    int         wr_delay = 0;
    int         wcnt = 0;
    bit         rd_respond = 1'b1;
    bit         rd_pending = 1'b0;
    logic [15:0] rd_addr = '0;
    int         wr_hs = 0;
    int         wv_run = 0;
    int         wv_max = 0;
    int         rd_hs_cyc = 0;
    int         tx_rise_cyc = 0;
    logic       prev_stall = 1'b0;
    logic       prev_txv = 1'b0;
    logic [7:0] prev_tx = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0)
                done = 1'b1;
        end
        check({name, "_complete"}, done, 1);
    endtask

    task automatic wait_wr(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (wr_hs >= n) done = 1'b1;
        end
        check("wait_write_handshake", done, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Ready/response drivers, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
            if (wr_delay == 0) begin
                bus.wready = 1'b1;
            end else if (bus.wready) begin
                bus.wready = 1'b0;
            end else if (bus.wvalid) begin
                wcnt++;
                if (wcnt >= wr_delay) begin
                    bus.wready = 1'b1;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor and read responder: sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall  = 1'b0;
                prev_txv    = 1'b0;
                wv_run      = 0;
                rd_pending  = 1'b0;
                bus.rrvalid = 1'b0;
            end else begin
                bus.rrvalid = rd_pending;
                if (rd_pending) bus.rdata = rd_addr + 16'h0100;
                rd_pending = 1'b0;

                if (prev_stall) begin
                    check("tx_hold_valid", tx_valid, 1);
                    check("tx_hold_data", tx_data, prev_tx);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_tx    = tx_data;
                if (tx_valid && !prev_txv) tx_rise_cyc = cyc;
                prev_txv = tx_valid;

                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) fail_now("tx_unexpected", tx_data);
                    else check("tx_byte", tx_data, exp_tx.pop_front());
                end

                if (bus.wvalid) wv_run++;
                if (bus.wvalid && bus.wready) begin
                    if (exp_wr.size() == 0) fail_now("wr_unexpected", {bus.address, bus.wdata});
                    else check("wr_addr_data", {bus.address, bus.wdata}, exp_wr.pop_front());
                    wr_hs++;
                    if (wv_run > wv_max) wv_max = wv_run;
                    wv_run = 0;
                end

                if (bus.rvalid && bus.rready) begin
                    if (exp_rd.size() == 0) fail_now("rd_unexpected", bus.address);
                    else check("rd_addr", bus.address, exp_rd.pop_front());
                    rd_hs_cyc = cyc;
                    if (rd_respond) begin
                        rd_pending = 1'b1;
                        rd_addr    = bus.address;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        bus.wready  = 1'b1;
        bus.rready  = 1'b1;
        bus.rrvalid = 1'b0;
        bus.rdata   = '0;

        #12;
        check("reset_outputs", {tx_valid, tx_data, bus.address, bus.wdata, bus.wvalid,
                                bus.rvalid, busy, rst_n_out}, 0);
        #10;
        rst_n = 1'b1;

        // Downstream reset control and ignored bytes.
        send_byte(8'hFF);
        check("rst_out_high", rst_n_out, 1);
        check("ff_not_busy", busy, 0);
        send_byte(8'hFE);
        check("rst_out_low", rst_n_out, 0);
        send_byte(8'hFF);
        check("rst_out_high_again", rst_n_out, 1);
        send_byte(8'h77);
        @(posedge clk);
        #1;
        check("junk_not_busy", busy, 0);
        check("junk_rst_out", rst_n_out, 1);

        // Single write with wready tied high.
        wv_max = 0;
        exp_wr.push_back({16'h1234, 16'hABCD});
        exp_tx.push_back(8'hA5);
        frame = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        send_frame();
        wait_idle("write");
        check("write_wvalid_cycles", wv_max, 1);

        // Burst read of three words with a stalling transmitter.
        tx_mode = 1;
        exp_rd.push_back(16'h1000);
        exp_rd.push_back(16'h1001);
        exp_rd.push_back(16'h1002);
        exp_tx = '{8'h00, 8'h11, 8'h01, 8'h11, 8'h02, 8'h11, 8'hA5};
        frame = '{8'h03, 8'h02, 8'h00, 8'h10};
        send_frame();
        wait_idle("burst_read");
        tx_mode = 0;
        check("burst_read_final_addr", bus.address, 16'h1003);

        // Burst write wrapping the address, with a slow wready.
        wr_delay = 3;
        wv_max = 0;
        exp_wr.push_back({16'hFFFF, 16'h2211});
        exp_wr.push_back({16'h0000, 16'h4433});
        exp_tx.push_back(8'hA5);
        frame = '{8'h04, 8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};
        send_frame();
        wait_wr(wr_hs + 1);
        frame = '{8'h33, 8'h44};
        send_frame();
        wait_idle("burst_write");
        check("burst_write_wvalid_held", wv_max >= 3, 1);
        check("burst_write_final_addr", bus.address, 16'h0001);
        wr_delay = 0;

        // Read that never gets a response.
        rd_respond = 1'b0;
        exp_rd.push_back(16'h2000);
        exp_tx = '{8'h00, 8'h00, 8'hEE};
        frame = '{8'h01, 8'h00, 8'h20};
        send_frame();
        wait_idle("timeout_read");
        check("timeout_latency", tx_rise_cyc - rd_hs_cyc, TO + 1);
        check("timeout_idle", busy, 0);
        rd_respond = 1'b1;

        // A byte arriving while the write is on the bus.
        wr_delay = 3;
        exp_wr.push_back({16'h3000, 16'h0201});
        exp_tx.push_back(8'hEE);
        frame = '{8'h02, 8'h00, 8'h30, 8'h01, 8'h02, 8'h55};
        send_frame();
        wait_idle("overrun");
        wr_delay = 0;

        // Asynchronous reset while a read response is being sent.
        tx_mode = 2;
        exp_rd.push_back(16'h4000);
        frame = '{8'h01, 8'h00, 8'h40};
        send_frame();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check("send_reached", seen, 1);
        check("send_first_byte", tx_data, 8'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_send", {tx_valid, tx_data, bus.address, bus.wdata, bus.wvalid,
                                 bus.rvalid, busy, rst_n_out}, 0);
        tx_mode = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        exp_wr.push_back({16'h5678, 16'hBEEF});
        exp_tx.push_back(8'hA5);
        frame = '{8'h02, 8'h78, 8'h56, 8'hEF, 8'hBE};
        send_frame();
        wait_idle("after_reset_write");

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_host_burst.md
Name: uart_host_burst

Overview:
- Byte-stream host bridge; successor to the single-word UART host.
- Sits between the UART core byte interface (rx_valid/rx_data, tx_valid/tx_data/tx_ready) and the on-chip memory bus.
- Adds burst read/write with address auto-increment, a full valid/ready bus handshake, read-response timeout, and a per-command status byte.

Parameters:
- ADDR_BYTE, 2, address width in bytes (1..4).
- DATA_BYTE, 2, data width in bytes (1..4).
- ADDR_INC, 1, address increment per word in a burst.
- TIMEOUT, 1024, max cycles waiting for rrvalid (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  received byte strobe, 1 cycle, no backpressure
- rx_data  in  8  received byte
- tx_valid  out  1  transmit byte valid
- tx_data  out  8  transmit byte
- tx_ready  in  1  transmitter accepts byte
- rst_n_out  out  1  downstream reset
- address  out  8*ADDR_BYTE  bus address
- wvalid  out  1  write request, held until wready
- wdata  out  8*DATA_BYTE  write data
- wready  in  1  write accept
- rvalid  out  1  read request, held until rready
- rready  in  1  read accept
- rrvalid  in  1  read response valid
- rdata  in  8*DATA_BYTE  read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 (rst_n_out=0, tx_valid=0, tx_data=0, address=0, wdata=0, wvalid=0, rvalid=0, busy=0). State=IDLE. Internal flags cleared.
- Reset mid-operation aborts immediately; no status byte is sent.
- Commands (first byte in IDLE):
  - 0x01 READ: N=1.
  - 0x02 WRITE: N=1.
  - 0x03 BURST_READ and 0x04 BURST_WRITE: followed by LEN byte, N=LEN+1 (1..256).
  - 0xFE: rst_n_out<=0 next cycle, stay IDLE, no response.
  - 0xFF: rst_n_out<=1 next cycle, stay IDLE, no response.
  - Any other byte: ignored, stay IDLE.
  - Only IDLE decodes commands; 0xFE/0xFF in later states are plain data.
- Frame after command [and LEN]: ADDR_BYTE address bytes, LSB first. For writes, N words of DATA_BYTE bytes each, LSB first.
- States: IDLE -> LEN (burst only) -> ADDR -> {DATA, RD_REQ}.
- Write path:
  - DATA: after the last byte of a word -> WR_BUS; wvalid=1 the following cycle with the assembled wdata.
  - WR_BUS: on wvalid&wready, wvalid drops next cycle and address += ADDR_INC (wraps modulo 2^(8*ADDR_BYTE)). Then -> DATA if words remain, else -> STATUS.
- Read path:
  - RD_REQ: rvalid=1. On rvalid&rready, rvalid drops next cycle -> RD_WAIT; timeout counter cleared.
  - RD_WAIT: rrvalid captures rdata -> SEND. If TIMEOUT cycles elapse without rrvalid, capture 0, set err flag -> SEND.
  - SEND: DATA_BYTE bytes, LSB first. Each byte advances on tx_valid&tx_ready. tx_data is stable while tx_valid && !tx_ready. After the last byte, address += ADDR_INC -> RD_REQ if words remain, else -> STATUS.
- STATUS: one byte, 0xA5 if err clear, 0xEE if err set. On tx_ready -> IDLE; err cleared.
- Overrun: rx_valid in WR_BUS, RD_REQ, RD_WAIT, SEND or STATUS drops the byte and sets err. The command still completes with its remaining words.
- A late rrvalid after timeout, arriving in any state other than RD_WAIT, is ignored.
- A read or write handshake presented in the same cycle valid rises is legal; the request lasts exactly 1 cycle.
- Counters: word counter 9 bits, byte counters $clog2(max(ADDR_BYTE,DATA_BYTE)+1) bits, timeout counter $clog2(TIMEOUT+1) bits.

Test Plan:
- WRITE: 02 34 12 CD AB with wready tied 1 -> one wvalid cycle, address=0x1234, wdata=0xABCD; tx byte A5.
- BURST_READ: 03 02 00 10, rdata = address+0x100, 1-cycle rrvalid -> 3 reads at 0x1000/0x1001/0x1002; tx 00 11 01 11 02 11 A5.
- BURST_WRITE at address 0xFFFF, LEN=1, wready delayed 3 cycles -> wvalid held 3+ cycles; addresses 0xFFFF then 0x0000; tx A5.
- READ with rrvalid never asserted, TIMEOUT=16 -> 16 cycles in RD_WAIT; tx 00 00 EE; then IDLE, busy=0.
- Reset commands: FE -> rst_n_out=0 next cycle, no tx. FF -> rst_n_out=1. Byte 0x77 in IDLE -> no state change.
- Overrun and async reset: rx byte during WR_BUS -> status EE. Separately, assert rst_n mid-SEND -> all outputs 0 immediately; next command frame works normally.
